// File: rtl/lookup3_stream_hash_pkg.sv
// Shared types, constants and helpers for the streaming lookup3 (hashlittle) engine.
package lookup3_stream_hash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_MIX   = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [31:0] MAGIC      = 32'hDEADBEEF;
    localparam logic [2:0]  MIX_LAST   = 3'd5;
    localparam logic [2:0]  FINAL_LAST = 3'd6;

    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] r);
        return (x << r) | (x >> (6'd32 - {1'b0, r}));
    endfunction

    function automatic logic [4:0] mix_rot(input logic [2:0] s);
        case (s)
            3'd0:    return 5'd4;
            3'd1:    return 5'd6;
            3'd2:    return 5'd8;
            3'd3:    return 5'd16;
            3'd4:    return 5'd19;
            default: return 5'd4;
        endcase
    endfunction

    function automatic logic [4:0] final_rot(input logic [2:0] s);
        case (s)
            3'd0:    return 5'd14;
            3'd1:    return 5'd11;
            3'd2:    return 5'd25;
            3'd3:    return 5'd16;
            3'd4:    return 5'd4;
            3'd5:    return 5'd14;
            default: return 5'd24;
        endcase
    endfunction

    // Number of valid bytes (0..4) in the word starting at byte offset base of a tail of rem bytes.
    function automatic logic [2:0] word_bytes(input logic [3:0] rem, input logic [3:0] base);
        logic [3:0] diff;
        diff = rem - base;
        if (rem >= base + 4'd4) return 3'd4;
        if (rem <= base) return 3'd0;
        return diff[2:0];
    endfunction

    function automatic logic [31:0] byte_mask(input logic [2:0] nbytes, input logic big_endian);
        logic [31:0] m;
        case (nbytes)
            3'd0:    m = 32'h0000_0000;
            3'd1:    m = 32'h0000_00FF;
            3'd2:    m = 32'h0000_FFFF;
            3'd3:    m = 32'h00FF_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        if (big_endian) m = {m[7:0], m[15:8], m[23:16], m[31:24]};
        return m;
    endfunction

endpackage

// File: rtl/lookup3_stream_hash_step.sv
// One lookup3 sub-step: a single line of mix() or final() applied to a/b/c.
module lookup3_stream_hash_step
    import lookup3_stream_hash_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] c_i,
    input  logic        final_i,
    input  logic [2:0]  step_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [31:0] c_o
);

    logic [4:0] rot;

    always_comb begin
        a_o = a_i;
        b_o = b_i;
        c_o = c_i;
        rot = final_i ? final_rot(step_i) : mix_rot(step_i);
        if (!final_i) begin
            // The (x,y,z) roles rotate with period three through the six mix lines.
            case (step_i)
                3'd0, 3'd3: begin
                    a_o = (a_i - c_i) ^ rotl32(c_i, rot);
                    c_o = c_i + b_i;
                end
                3'd1, 3'd4: begin
                    b_o = (b_i - a_i) ^ rotl32(a_i, rot);
                    a_o = a_i + c_i;
                end
                default: begin
                    c_o = (c_i - b_i) ^ rotl32(b_i, rot);
                    b_o = b_i + a_i;
                end
            endcase
        end else begin
            case (step_i)
                3'd0, 3'd3, 3'd6: c_o = (c_i ^ b_i) - rotl32(b_i, rot);
                3'd1, 3'd4:       a_o = (a_i ^ c_i) - rotl32(c_i, rot);
                default:          b_o = (b_i ^ a_i) - rotl32(a_i, rot);
            endcase
        end
    end

endmodule

// File: rtl/lookup3_stream_hash.sv
// Streaming Jenkins lookup3 hashlittle: 12-byte beats in, one mix/final line per cycle, hash out.
// Handshakes: a transfer happens on a CLK rise where valid && ready; valid holds its payload until then.
module lookup3_stream_hash
    import lookup3_stream_hash_pkg::*;
#(
    parameter int          LEN_W      = 8,
    parameter logic [31:0] INITVAL    = 32'h0,
    parameter bit          BIG_ENDIAN = 1'b0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LEN_W-1:0] in_len,
    input  logic [31:0]      in_k0,
    input  logic [31:0]      in_k1,
    input  logic [31:0]      in_k2,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_hash,
    output logic             out_err,
    output logic [2:0]       dbg_state_o
);

    state_e           state_q;
    logic [2:0]       step_q;
    logic [LEN_W-1:0] rem_q;
    logic [31:0]      a_q, b_q, c_q;
    logic             in_ready_q, out_valid_q, err_q;
    logic [31:0]      hash_q;

    logic             first, accept, more, mismatch;
    logic [31:0]      magic, base_a, base_b, base_c;
    logic [LEN_W-1:0] rem_cur;
    logic [3:0]       tail4;
    logic [31:0]      k0_eff, k1_eff, k2_eff;
    logic [31:0]      st_a, st_b, st_c;

    assign first   = (state_q == ST_IDLE);
    assign accept  = in_valid && in_ready_q;
    assign magic   = MAGIC + INITVAL + 32'(in_len);
    assign base_a  = first ? magic : a_q;
    assign base_b  = first ? magic : b_q;
    assign base_c  = first ? magic : c_q;
    assign rem_cur = first ? in_len : rem_q;
    assign more    = (rem_cur > LEN_W'(12));
    assign tail4   = rem_cur[3:0];

    // Producer framing is only cross-checked; the byte count decides which beat is last.
    assign mismatch = in_last ? more : !more;

    assign k0_eff = more ? in_k0 : (in_k0 & byte_mask(word_bytes(tail4, 4'd0), BIG_ENDIAN));
    assign k1_eff = more ? in_k1 : (in_k1 & byte_mask(word_bytes(tail4, 4'd4), BIG_ENDIAN));
    assign k2_eff = more ? in_k2 : (in_k2 & byte_mask(word_bytes(tail4, 4'd8), BIG_ENDIAN));

    lookup3_stream_hash_step u_step (
        .a_i     (a_q),
        .b_i     (b_q),
        .c_i     (c_q),
        .final_i (state_q == ST_FINAL),
        .step_i  (step_q),
        .a_o     (st_a),
        .b_o     (st_b),
        .c_o     (st_c)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            step_q      <= 3'd0;
            rem_q       <= '0;
            a_q         <= 32'h0;
            b_q         <= 32'h0;
            c_q         <= 32'h0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            hash_q      <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_LOAD: begin
                    if (accept) begin
                        err_q      <= first ? mismatch : (err_q | mismatch);
                        step_q     <= 3'd0;
                        in_ready_q <= 1'b0;
                        if (rem_cur == '0) begin
                            // Empty key: hashlittle returns the seeded c with no final mix.
                            a_q         <= base_a;
                            b_q         <= base_b;
                            c_q         <= base_c;
                            rem_q       <= '0;
                            hash_q      <= base_c;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            a_q     <= base_a + k0_eff;
                            b_q     <= base_b + k1_eff;
                            c_q     <= base_c + k2_eff;
                            rem_q   <= more ? (rem_cur - LEN_W'(12)) : '0;
                            state_q <= more ? ST_MIX : ST_FINAL;
                        end
                    end
                end
                ST_MIX: begin
                    a_q <= st_a;
                    b_q <= st_b;
                    c_q <= st_c;
                    if (step_q == MIX_LAST) begin
                        step_q     <= 3'd0;
                        in_ready_q <= 1'b1;
                        state_q    <= ST_LOAD;
                    end else begin
                        step_q <= step_q + 3'd1;
                    end
                end
                ST_FINAL: begin
                    a_q <= st_a;
                    b_q <= st_b;
                    c_q <= st_c;
                    if (step_q == FINAL_LAST) begin
                        step_q      <= 3'd0;
                        hash_q      <= st_c;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        step_q <= step_q + 3'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    step_q      <= 3'd0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_hash    = hash_q;
    assign out_err     = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lookup3_stream_hash.sv
// Bench for lookup3_stream_hash: three seeds, directed keys, queue scoreboard with a result monitor.
module tb_lookup3_stream_hash;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [7:0]  in_len;
    logic [31:0] in_k0, in_k1, in_k2;
    logic        in_last;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic        out_err   [3];
    logic [31:0] out_hash  [3];
    logic [2:0]  dbg_state [3];

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];
    logic [32:0] exp_q2[$];
    logic [7:0]  key_buf [48];

    localparam string FOUR = "Four score and seven years ago";

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- DUTs: seeds 0, 1 and DEADBEEF share the data bus ----------------
    lookup3_stream_hash #(.LEN_W(8), .INITVAL(32'h0), .BIG_ENDIAN(1'b0)) u0 (
        .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_len(in_len), .in_k0(in_k0), .in_k1(in_k1), .in_k2(in_k2), .in_last(in_last),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_hash(out_hash[0]),
        .out_err(out_err[0]), .dbg_state_o(dbg_state[0]));

    lookup3_stream_hash #(.LEN_W(8), .INITVAL(32'h1), .BIG_ENDIAN(1'b0)) u1 (
        .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_len(in_len), .in_k0(in_k0), .in_k1(in_k1), .in_k2(in_k2), .in_last(in_last),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_hash(out_hash[1]),
        .out_err(out_err[1]), .dbg_state_o(dbg_state[1]));

    lookup3_stream_hash #(.LEN_W(8), .INITVAL(32'hDEADBEEF), .BIG_ENDIAN(1'b0)) u2 (
        .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_len(in_len), .in_k0(in_k0), .in_k1(in_k1), .in_k2(in_k2), .in_last(in_last),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_hash(out_hash[2]),
        .out_err(out_err[2]), .dbg_state_o(dbg_state[2]));

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int idx, input logic [32:0] v);
        case (idx)
            0:       exp_q0.push_back(v);
            1:       exp_q1.push_back(v);
            default: exp_q2.push_back(v);
        endcase
    endtask

    function automatic int pending();
        return exp_q0.size() + exp_q1.size() + exp_q2.size();
    endfunction

    // Reference hashlittle written straight from the published algorithm, byte-addressed.
    function automatic logic [31:0] rot(input logic [31:0] x, input int k);
        return (x << k) | (x >> (32 - k));
    endfunction

    function automatic logic [31:0] tail_word(input int off, input int n, input int w);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < 4; i++)
            if (4 * w + i < n) v = v | (32'(key_buf[off + 4 * w + i]) << (8 * i));
        return v;
    endfunction

    function automatic logic [31:0] ref_hash(input int len, input logic [31:0] initval);
        logic [31:0] a, b, c;
        int n, off;
        a = 32'hDEADBEEF + 32'(len) + initval;
        b = a;
        c = a;
        n = len;
        off = 0;
        if (n == 0) return c;
        while (n > 12) begin
            a += tail_word(off, 12, 0);
            b += tail_word(off, 12, 1);
            c += tail_word(off, 12, 2);
            a -= c; a ^= rot(c, 4);  c += b;
            b -= a; b ^= rot(a, 6);  a += c;
            c -= b; c ^= rot(b, 8);  b += a;
            a -= c; a ^= rot(c, 16); c += b;
            b -= a; b ^= rot(a, 19); a += c;
            c -= b; c ^= rot(b, 4);  b += a;
            n -= 12;
            off += 12;
        end
        a += tail_word(off, n, 0);
        b += tail_word(off, n, 1);
        c += tail_word(off, n, 2);
        c ^= b; c -= rot(b, 14);
        a ^= c; a -= rot(c, 11);
        b ^= a; b -= rot(a, 25);
        c ^= b; c -= rot(b, 16);
        a ^= c; a -= rot(c, 4);
        b ^= a; b -= rot(a, 14);
        c ^= b; c -= rot(b, 24);
        return c;
    endfunction

    // Bytes past the key length are deliberately non-zero so tail masking matters.
    task automatic load_str(input string s);
        for (int i = 0; i < 48; i++)
            key_buf[i] = (i < s.len()) ? s[i] : 8'(8'hC3 + 8'(i * 11));
    endtask

    task automatic load_pattern(input int seed);
        for (int i = 0; i < 48; i++) key_buf[i] = 8'(seed * 7 + i * 29 + 3);
    endtask

    // ---------------- driver ----------------
    // bad_beat flips in_last on that beat; stop_after>0 sends only that many beats and expects nothing.
    task automatic send_key(input int idx, input int len, input int bad_beat,
                            input logic [31:0] exp_hash, input logic exp_err,
                            input bit chk_gap, input int exp_lat, input int stop_after);
        int nbeats, lim, cnt, g;
        nbeats = (len == 0) ? 1 : (len + 11) / 12;
        lim    = (stop_after > 0) ? stop_after : nbeats;
        if (stop_after == 0) push_exp(idx, {exp_err, exp_hash});
        for (int bt = 0; bt < lim; bt++) begin
            in_len  = 8'(len);
            in_k0   = {key_buf[12*bt+3],  key_buf[12*bt+2],  key_buf[12*bt+1],  key_buf[12*bt]};
            in_k1   = {key_buf[12*bt+7],  key_buf[12*bt+6],  key_buf[12*bt+5],  key_buf[12*bt+4]};
            in_k2   = {key_buf[12*bt+11], key_buf[12*bt+10], key_buf[12*bt+9],  key_buf[12*bt+8]};
            in_last = (bt == nbeats - 1) ^ (bt == bad_beat);
            in_valid[idx] = 1'b1;
            cnt = 0;
            while (!in_ready[idx] && cnt < 200) begin
                @(negedge CLK);
                cnt++;
            end
            if (!in_ready[idx]) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout u%0d beat %0d: in_ready=0 after %0d cycles, required 1",
                         idx, bt, cnt);
                in_valid[idx] = 1'b0;
                return;
            end
            @(posedge CLK);
            #1;
            in_valid[idx] = 1'b0;
            if (bt < nbeats - 1 && chk_gap) begin
                g = 0;
                while (g < 100) begin
                    @(negedge CLK);
                    if (in_ready[idx]) break;
                    g++;
                end
                check($sformatf("ready_gap_u%0d_len%0d_beat%0d", idx, len, bt), 64'(g), 64'd6);
            end
            if (bt == nbeats - 1 && exp_lat >= 0) begin
                g = 0;
                while (g < 100) begin
                    @(negedge CLK);
                    if (out_valid[idx]) break;
                    g++;
                end
                check($sformatf("latency_u%0d_len%0d", idx, len), 64'(g), 64'(exp_lat));
            end
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic check_result(input int idx);
        logic [32:0] act, e;
        bit got;
        act = {out_err[idx], out_hash[idx]};
        got = 1'b0;
        e   = '0;
        case (idx)
            0:       if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); got = 1'b1; end
            1:       if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); got = 1'b1; end
            default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); got = 1'b1; end
        endcase
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result_u%0d: got {err,hash}=%0h, required no output", idx, act);
        end else begin
            check($sformatf("result_u%0d", idx), 64'(act), 64'(e));
        end
    endtask

    always @(negedge CLK) begin
        if (RST_N) begin
            for (int i = 0; i < 3; i++)
                if (out_valid[i] && out_ready[i]) check_result(i);
        end
    end

    // ---------------- stimulus ----------------
    int lens [10] = '{1, 4, 5, 8, 9, 11, 12, 13, 24, 25};

    initial begin
        int cnt;
        RST_N   = 1'b0;
        in_len  = 8'h0;
        in_k0   = 32'h0;
        in_k1   = 32'h0;
        in_k2   = 32'h0;
        in_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b1;
        end
        repeat (2) @(posedge CLK);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_in_ready_u%0d", i),  64'(in_ready[i]),  64'd1);
            check($sformatf("reset_out_valid_u%0d", i), 64'(out_valid[i]), 64'd0);
            check($sformatf("reset_out_hash_u%0d", i),  64'(out_hash[i]),  64'd0);
            check($sformatf("reset_out_err_u%0d", i),   64'(out_err[i]),   64'd0);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        // Empty keys: result is the seeded magic, visible right after the accept edge.
        load_pattern(17);
        send_key(0, 0, -1, 32'hDEADBEEF, 1'b0, 1'b0, 0, 0);
        send_key(1, 0, -1, 32'hDEADBEF0, 1'b0, 1'b0, 0, 0);
        send_key(2, 0, -1, 32'hBD5B7DDE, 1'b0, 1'b0, 0, 0);

        // Published three-beat vectors; 6-cycle ready gaps after beats 1 and 2.
        load_str(FOUR);
        send_key(0, 30, -1, 32'h17770551, 1'b0, 1'b1, 7, 0);
        send_key(1, 30, -1, 32'hCD628161, 1'b0, 1'b1, 7, 0);

        // Tail-length sweep, including exact multiples of 12.
        foreach (lens[i]) begin
            load_pattern(lens[i] + 40);
            send_key(0, lens[i], -1, ref_hash(lens[i], 32'h0), 1'b0, lens[i] > 12, 7, 0);
        end
        load_pattern(99);
        send_key(2, 17, -1, ref_hash(17, 32'hDEADBEEF), 1'b0, 1'b1, 7, 0);

        // Output backpressure: result must hold and a new beat must not be taken.
        load_str(FOUR);
        out_ready[0] = 1'b0;
        send_key(0, 30, -1, 32'h17770551, 1'b0, 1'b0, 7, 0);
        in_len  = 8'h0;
        in_last = 1'b1;
        in_valid[0] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            check($sformatf("hold_valid_c%0d", c), 64'(out_valid[0]), 64'd1);
            check($sformatf("hold_hash_c%0d", c),  64'(out_hash[0]),  64'h17770551);
            check($sformatf("hold_ready_c%0d", c), 64'(in_ready[0]),  64'd0);
            @(negedge CLK);
        end
        in_valid[0] = 1'b0;
        @(posedge CLK);
        #1;
        out_ready[0] = 1'b1;

        // Framing errors: early in_last, then missing in_last; error clears on the next key.
        load_pattern(64);
        send_key(0, 13, 0, ref_hash(13, 32'h0), 1'b1, 1'b1, 7, 0);
        load_pattern(65);
        send_key(0, 5, -1, ref_hash(5, 32'h0), 1'b0, 1'b0, 7, 0);
        load_pattern(66);
        send_key(0, 24, 1, ref_hash(24, 32'h0), 1'b1, 1'b1, 7, 0);

        // Reset while beat 2 is mixing drops the key; the next key is unaffected.
        load_str(FOUR);
        send_key(0, 30, -1, 32'h0, 1'b0, 1'b0, -1, 2);
        repeat (2) @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        check("midreset_in_ready",  64'(in_ready[0]),  64'd1);
        check("midreset_out_valid", 64'(out_valid[0]), 64'd0);
        check("midreset_out_hash",  64'(out_hash[0]),  64'd0);
        check("midreset_out_err",   64'(out_err[0]),   64'd0);
        check("midreset_state",     64'(dbg_state[0]), 64'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        send_key(0, 30, -1, 32'h17770551, 1'b0, 1'b1, 7, 0);

        cnt = 0;
        while (pending() != 0 && cnt < 1000) begin
            @(negedge CLK);
            cnt++;
        end
        if (pending() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d results outstanding, required 0", pending());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
